// File: rtl/alu_seq_pkg.sv
// Shared opcode, status-bit and FSM-state constants for alu_seq.
// The ALU_SEQ_MUL_EN macro enables the multiplier; this package is identical in both builds.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOTB = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative W-step shift-add unsigned multiplier producing a 2W-bit product.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;

    // Load operands on start, otherwise take one shift-add step while steps remain.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            cnt_d    = CW'(W);
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = {2*W{1'b0}};
        end else if (cnt_q != {CW{1'b0}}) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : {2*W{1'b0}});
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
        end else begin
            acc_d    = acc_q;
        end
    end

    // Done flags the edge that performs the final step; product_o already includes it.
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_d;

    // Multiplier state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {2*W{1'b0}};
            mplier_q <= {W{1'b0}};
            acc_q    <= {2*W{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit ALU with a registered result and {V,N,Z} status.
// Define ALU_SEQ_MUL_EN to add the iterative MUL opcode (BUSY/HOLD states and alu_seq_mul).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    input  logic [2:0]   ALUop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [2:0]   status
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [2:0]   status_q, status_d;
    logic         out_valid_q, out_valid_d;
    logic         slot_free_s;
    logic         accept_s;
    logic [W-1:0] sc_res_s;
    logic         sc_v_s;

    function automatic logic [2:0] pack_status(input logic v, input logic [W-1:0] r);
        logic [2:0] s;
        s       = 3'b000;
        s[ST_V] = v;
        s[ST_N] = r[W-1];
        s[ST_Z] = (r == {W{1'b0}});
        return s;
    endfunction

    assign slot_free_s = !out_valid_q || out_ready;
    assign in_ready    = (state_q == IDLE) && slot_free_s;
    assign accept_s    = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    logic           mul_start_s;
    logic           mul_done_s;
    logic [2*W-1:0] mul_prod_s;

    alu_seq_mul #(
        .W(W)
    ) u_mul (
        .clk       (clk),
        .rst       (reset),
        .start_i   (mul_start_s),
        .a_i       (Ain),
        .b_i       (Bin),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );
`endif

    // Single-cycle datapath; reserved opcodes fall through to zero, which yields status 001.
    always_comb begin
        sc_res_s = {W{1'b0}};
        sc_v_s   = 1'b0;
        case (ALUop)
            OP_ADD: begin
                sc_res_s = Ain + Bin;
                sc_v_s   = (Ain[W-1] == Bin[W-1]) && (sc_res_s[W-1] != Ain[W-1]);
            end
            OP_SUB: begin
                sc_res_s = Ain - Bin;
                sc_v_s   = (Ain[W-1] != Bin[W-1]) && (sc_res_s[W-1] != Ain[W-1]);
            end
            OP_AND:  sc_res_s = Ain & Bin;
            OP_NOTB: sc_res_s = ~Bin;
            default: sc_res_s = {W{1'b0}};
        endcase
    end

    // Control FSM and output-slot management.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        status_d    = status_q;
        out_valid_d = out_valid_q && !out_ready;
`ifdef ALU_SEQ_MUL_EN
        mul_start_s = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
`ifdef ALU_SEQ_MUL_EN
                    if (ALUop == OP_MUL) begin
                        mul_start_s = 1'b1;
                        state_d     = BUSY;
                    end else begin
                        out_d       = sc_res_s;
                        status_d    = pack_status(sc_v_s, sc_res_s);
                        out_valid_d = 1'b1;
                    end
`else
                    out_d       = sc_res_s;
                    status_d    = pack_status(sc_v_s, sc_res_s);
                    out_valid_d = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (mul_done_s && slot_free_s) begin
                    out_d       = mul_prod_s[W-1:0];
                    status_d    = pack_status(|mul_prod_s[2*W-1:W], mul_prod_s[W-1:0]);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (mul_done_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = BUSY;
                end
            end
            HOLD: begin
                // Product waits in the multiplier accumulator until the old result is consumed.
                if (out_valid_q && out_ready) begin
                    out_d       = mul_prod_s[W-1:0];
                    status_d    = pack_status(|mul_prod_s[2*W-1:W], mul_prod_s[W-1:0]);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Result, status and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_q       <= {W{1'b0}};
            status_q    <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign status    = status_q;
    assign out_valid = out_valid_q;

endmodule
